// File: rtl/bram_dp.sv
// True-dual-port block RAM with configurable width, depth and read latency.
// Per-read valid strobe, byte-lane writes, collision rules, sticky out-of-range flag.
//
// Ports (x = a | b):
//   clk, rst        rising-edge clock, async active-low reset
//   x_en            port enable (read; write when any x_wen bit set)
//   x_wen           byte-lane write enables
//   x_addr          byte or word address (BYTE_ADDR)
//   x_din           write data
//   x_dout          read data, held between completions
//   x_rvalid        one-cycle pulse per completed read
//   oob_err         sticky out-of-range access flag
module bram_dp #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4096,
  parameter int RD_LAT      = 1,
  parameter int BYTE_ADDR   = 1,
  parameter int WRITE_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_en,
  input  logic [DATA_W/8-1:0] a_wen,
  input  logic [31:0]       a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic [DATA_W-1:0] a_dout,
  output logic              a_rvalid,
  input  logic              b_en,
  input  logic [DATA_W/8-1:0] b_wen,
  input  logic [31:0]       b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic [DATA_W-1:0] b_dout,
  output logic              b_rvalid,
  output logic              oob_err
);

  localparam int BW = DATA_W / 8;
  localparam int LB = (BW > 1) ? $clog2(BW) : 0;
  localparam int SH = (BYTE_ADDR != 0) ? LB : 0;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              en   [2];
  logic [BW-1:0]     wen  [2];
  logic [31:0]       idx  [2];
  logic [DATA_W-1:0] din  [2];
  logic              inr  [2];
  logic              wr   [2];
  logic [DATA_W-1:0] rd_d [2];
  logic [DATA_W-1:0] dout [2];
  logic              rv   [2];
  logic              oob_q;

  assign en[0]  = a_en;
  assign en[1]  = b_en;
  assign wen[0] = a_wen;
  assign wen[1] = b_wen;
  assign din[0] = a_din;
  assign din[1] = b_din;
  // Full 32-bit index: high bits are kept so large addresses never alias.
  assign idx[0] = a_addr >> SH;
  assign idx[1] = b_addr >> SH;

  function automatic logic [DATA_W-1:0] merge(
    input logic [DATA_W-1:0] w,
    input logic [BW-1:0]     m,
    input logic [DATA_W-1:0] d
  );
    logic [DATA_W-1:0] r;
    r = w;
    for (int k = 0; k < BW; k++)
      if (m[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [DATA_W-1:0] old;
    logic [DATA_W-1:0] post;
    logic              hit_a;
    logic              hit_b;
    logic [RD_LAT-1:0] v_q;
    logic [DATA_W-1:0] d_q [RD_LAT];

    assign inr[p] = idx[p] < 32'(DEPTH);
    // Writes on an edge with reset low are dropped.
    assign wr[p]  = rst & en[p] & (|wen[p]) & inr[p];
    assign old    = inr[p] ? mem[idx[p][IW-1:0]] : '0;
    assign hit_a  = wr[0] && (idx[0] == idx[p]);
    assign hit_b  = wr[1] && (idx[1] == idx[p]);
    // Post-write word: B lanes first, A lanes on top (A wins).
    assign post   = merge(merge(old, hit_b ? wen[1] : '0, din[1]),
                          hit_a ? wen[0] : '0, din[0]);
    // Only a writing port may see its own new data; readers see old.
    assign rd_d[p] = ((WRITE_FIRST != 0) && wr[p]) ? post : old;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v_q <= '0;
        for (int i = 0; i < RD_LAT; i++) d_q[i] <= '0;
      end else begin
        v_q[0] <= en[p];
        // The output stage only loads on a completing read.
        if (RD_LAT > 1 || en[p]) d_q[0] <= rd_d[p];
        for (int i = 1; i < RD_LAT; i++) begin
          v_q[i] <= v_q[i-1];
          if (i < RD_LAT - 1 || v_q[i-1]) d_q[i] <= d_q[i-1];
        end
      end
    end

    assign dout[p] = d_q[RD_LAT-1];
    assign rv[p]   = v_q[RD_LAT-1];
  end

  // Port B is applied first so port A overrides on shared lanes.
  always_ff @(posedge clk) begin
    for (int p = 1; p >= 0; p--)
      for (int k = 0; k < BW; k++)
        if (wr[p] && wen[p][k])
          mem[idx[p][IW-1:0]][8*k +: 8] <= din[p][8*k +: 8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) oob_q <= 1'b0;
    else if ((en[0] && !inr[0]) || (en[1] && !inr[1])) oob_q <= 1'b1;
  end

  assign a_dout   = dout[0];
  assign a_rvalid = rv[0];
  assign b_dout   = dout[1];
  assign b_rvalid = rv[1];
  assign oob_err  = oob_q;

endmodule

// File: tb/tb_bram_dp.sv
// Directed bench for bram_dp: three instances with RD_LAT 1/2/3,
// WRITE_FIRST 0/1/0, driven by shared stimulus.
module tb_bram_dp;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_en, b_en;
  logic [3:0]  a_wen, b_wen;
  logic [31:0] a_addr, b_addr, a_din, b_din;
  logic [31:0] ad [3];
  logic [31:0] bd [3];
  logic        av [3];
  logic        bv [3];
  logic        oob [3];

  int nvec = 0;
  int nerr = 0;
  int lat [3] = '{1, 2, 3};
  int wf  [3] = '{0, 1, 0};

  always #5 clk = ~clk;

  bram_dp #(.RD_LAT(1), .WRITE_FIRST(0)) u1 (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_wen(a_wen), .a_addr(a_addr), .a_din(a_din),
    .a_dout(ad[0]), .a_rvalid(av[0]),
    .b_en(b_en), .b_wen(b_wen), .b_addr(b_addr), .b_din(b_din),
    .b_dout(bd[0]), .b_rvalid(bv[0]), .oob_err(oob[0]));

  bram_dp #(.RD_LAT(2), .WRITE_FIRST(1)) u2 (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_wen(a_wen), .a_addr(a_addr), .a_din(a_din),
    .a_dout(ad[1]), .a_rvalid(av[1]),
    .b_en(b_en), .b_wen(b_wen), .b_addr(b_addr), .b_din(b_din),
    .b_dout(bd[1]), .b_rvalid(bv[1]), .oob_err(oob[1]));

  bram_dp #(.RD_LAT(3), .WRITE_FIRST(0)) u3 (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_wen(a_wen), .a_addr(a_addr), .a_din(a_din),
    .a_dout(ad[2]), .a_rvalid(av[2]),
    .b_en(b_en), .b_wen(b_wen), .b_addr(b_addr), .b_din(b_din),
    .b_dout(bd[2]), .b_rvalid(bv[2]), .oob_err(oob[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_en = 0; b_en = 0; a_wen = 0; b_wen = 0;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  task automatic wr_a(input logic [31:0] addr, input logic [31:0] d,
                      input logic [3:0] m);
    a_en = 1; a_addr = addr; a_din = d; a_wen = m;
    tick();
    idle();
  endtask

  task automatic test_reset();
    wr_a(32'h0, 32'hDEADBEEF, 4'hF);
    drain();
    a_en = 1; a_addr = 0; b_en = 1; b_addr = 0;
    tick();
    drain();
    rst = 0;
    #2;
    for (int i = 0; i < 3; i++) begin
      nvec++; if (ad[i] !== 32'h0) begin nerr++; $display("FAIL rst_adout[%0d] got %h want 0", i, ad[i]); end
      nvec++; if (bd[i] !== 32'h0) begin nerr++; $display("FAIL rst_bdout[%0d] got %h want 0", i, bd[i]); end
      nvec++; if (av[i] !== 1'b0) begin nerr++; $display("FAIL rst_av[%0d] got %b want 0", i, av[i]); end
      nvec++; if (bv[i] !== 1'b0) begin nerr++; $display("FAIL rst_bv[%0d] got %b want 0", i, bv[i]); end
      nvec++; if (oob[i] !== 1'b0) begin nerr++; $display("FAIL rst_oob[%0d] got %b want 0", i, oob[i]); end
    end
    #1 rst = 1;
    b_en = 1; b_addr = 0;
    tick();
    idle();
    nvec++; if (bd[0] !== 32'hDEADBEEF) begin nerr++; $display("FAIL rst_keepmem got %h want deadbeef", bd[0]); end
    drain();
  endtask

  task automatic test_latency();
    logic [31:0] d [4];
    int j;
    bit ev;
    wr_a(32'h10, 32'h11223344, 4'hF);
    for (int k = 0; k < 4; k++) begin
      d[k] = 32'hA5000008 + k;
      wr_a(32'h20 + 4 * k, d[k], 4'hF);
    end
    drain();
    a_en = 1; a_addr = 32'h10;
    tick();
    idle();
    for (int c = 1; c <= 3; c++) begin
      for (int i = 0; i < 3; i++) begin
        nvec++; if (av[i] !== (lat[i] == c)) begin nerr++; $display("FAIL lat_valid[%0d] c%0d got %b want %b", i, c, av[i], lat[i] == c); end
        if (lat[i] == c) begin
          nvec++; if (ad[i] !== 32'h11223344) begin nerr++; $display("FAIL lat_data[%0d] got %h want 11223344", i, ad[i]); end
        end
      end
      if (c < 3) tick();
    end
    drain();
    for (int c = 0; c < 7; c++) begin
      if (c < 4) begin a_en = 1; a_addr = 32'h20 + 4 * c; end
      else idle();
      tick();
      for (int i = 0; i < 3; i++) begin
        j = c - (lat[i] - 1);
        ev = (j >= 0) && (j < 4);
        nvec++; if (av[i] !== ev) begin nerr++; $display("FAIL b2b_valid[%0d] c%0d got %b want %b", i, c, av[i], ev); end
        if (ev) begin
          nvec++; if (ad[i] !== d[j]) begin nerr++; $display("FAIL b2b_data[%0d] c%0d got %h want %h", i, c, ad[i], d[j]); end
        end
      end
    end
    drain();
    nvec++; if (ad[0] !== d[3] || av[0] !== 1'b0) begin nerr++; $display("FAIL hold got %h/%b want %h/0", ad[0], av[0], d[3]); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] e;
    wr_a(32'h14, 32'hFFFFFFFF, 4'hF);
    drain();
    a_en = 1; a_addr = 32'h14; a_din = 32'h00AB00CD; a_wen = 4'b0101;
    tick();
    idle();
    for (int c = 1; c <= 3; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (lat[i] == c) begin
          e = (wf[i] != 0) ? 32'hFFABFFCD : 32'hFFFFFFFF;
          nvec++; if (av[i] !== 1'b1 || ad[i] !== e) begin nerr++; $display("FAIL lane_dout[%0d] got %h/%b want %h/1", i, ad[i], av[i], e); end
        end
      end
      if (c < 3) tick();
    end
    drain();
    b_en = 1; b_addr = 32'h14;
    tick();
    idle();
    nvec++; if (bd[0] !== 32'hFFABFFCD) begin nerr++; $display("FAIL lane_mem got %h want ffabffcd", bd[0]); end
    drain();
  endtask

  task automatic test_collision();
    logic [31:0] e;
    a_en = 1; a_addr = 32'h1C; a_din = 32'h11111111; a_wen = 4'hF;
    b_en = 1; b_addr = 32'h1C; b_din = 32'h22222222; b_wen = 4'h3;
    tick();
    drain();
    b_en = 1; b_addr = 32'h1C;
    tick();
    idle();
    nvec++; if (bd[0] !== 32'h11111111) begin nerr++; $display("FAIL coll_ww got %h want 11111111", bd[0]); end
    wr_a(32'h1C, 32'h0, 4'hF);
    drain();
    a_en = 1; a_addr = 32'h1C; a_din = 32'h33333333; a_wen = 4'hF;
    b_en = 1; b_addr = 32'h1C;
    tick();
    idle();
    for (int c = 1; c <= 3; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (lat[i] == c) begin
          nvec++; if (bv[i] !== 1'b1 || bd[i] !== 32'h0) begin nerr++; $display("FAIL coll_rd[%0d] got %h/%b want 0/1", i, bd[i], bv[i]); end
          e = (wf[i] != 0) ? 32'h33333333 : 32'h0;
          nvec++; if (ad[i] !== e) begin nerr++; $display("FAIL coll_wr[%0d] got %h want %h", i, ad[i], e); end
        end
      end
      if (c < 3) tick();
    end
    drain();
    a_en = 1; a_addr = 32'h1C; a_din = 32'h11111111; a_wen = 4'h3;
    b_en = 1; b_addr = 32'h1C; b_din = 32'h22222222; b_wen = 4'h6;
    tick();
    drain();
    b_en = 1; b_addr = 32'h1C;
    tick();
    idle();
    nvec++; if (bd[0] !== 32'h33221111) begin nerr++; $display("FAIL coll_merge got %h want 33221111", bd[0]); end
    drain();
  endtask

  task automatic test_oob();
    a_en = 0; a_addr = 32'h4000; a_wen = 4'hF; a_din = 32'h12345678;
    tick();
    nvec++; if (oob[0] !== 1'b0 || av[0] !== 1'b0) begin nerr++; $display("FAIL oob_dis got %b/%b want 0/0", oob[0], av[0]); end
    wr_a(32'h4000, 32'h12345678, 4'hF);
    for (int i = 0; i < 3; i++) begin
      nvec++; if (oob[i] !== 1'b1) begin nerr++; $display("FAIL oob_set[%0d] got %b want 1", i, oob[i]); end
    end
    nvec++; if (av[0] !== 1'b1 || ad[0] !== 32'h0) begin nerr++; $display("FAIL oob_rd got %h/%b want 0/1", ad[0], av[0]); end
    drain();
    b_en = 1; b_addr = 32'h0;
    tick();
    idle();
    nvec++; if (bd[0] !== 32'hDEADBEEF) begin nerr++; $display("FAIL oob_alias got %h want deadbeef", bd[0]); end
    for (int k = 0; k < 10; k++) begin
      a_en = 1; a_addr = 32'h10;
      tick();
      nvec++; if (oob[0] !== 1'b1) begin nerr++; $display("FAIL oob_sticky k%0d got %b want 1", k, oob[0]); end
    end
    idle();
    rst = 0;
    #2;
    for (int i = 0; i < 3; i++) begin
      nvec++; if (oob[i] !== 1'b0) begin nerr++; $display("FAIL oob_clr[%0d] got %b want 0", i, oob[i]); end
    end
    #1 rst = 1;
    b_en = 1; b_addr = 32'h10;
    tick();
    b_addr = 32'h4004;
    tick();
    idle();
    nvec++; if (bv[0] !== 1'b1 || bd[0] !== 32'h0 || oob[0] !== 1'b1) begin nerr++; $display("FAIL oob_brd got %h/%b/%b want 0/1/1", bd[0], bv[0], oob[0]); end
    drain();
  endtask

  task automatic test_reset_mid_read();
    a_en = 1; a_addr = 32'h10;
    tick();
    idle();
    tick();
    rst = 0;
    tick();
    nvec++; if (av[2] !== 1'b0 || ad[2] !== 32'h0) begin nerr++; $display("FAIL mid_flush got %h/%b want 0/0", ad[2], av[2]); end
    rst = 1;
    tick();
    nvec++; if (av[2] !== 1'b0) begin nerr++; $display("FAIL mid_after got %b want 0", av[2]); end
    a_en = 1; a_addr = 32'h10;
    tick();
    idle();
    for (int c = 1; c <= 3; c++) begin
      nvec++; if (av[2] !== (c == 3)) begin nerr++; $display("FAIL mid_valid c%0d got %b want %b", c, av[2], c == 3); end
      if (c < 3) tick();
    end
    nvec++; if (ad[2] !== 32'h11223344) begin nerr++; $display("FAIL mid_data got %h want 11223344", ad[2]); end
    drain();
  endtask

  initial begin
    rst = 1;
    idle();
    a_addr = 0; b_addr = 0; a_din = 0; b_din = 0;
    #2 rst = 0;
    repeat (2) tick();
    rst = 1;
    tick();
    test_reset();
    test_latency();
    test_byte_lanes();
    test_collision();
    test_oob();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
